// File: rtl/mon_pkg.sv
// Shared definitions for the monitor step controller.
// Op codes, controller states and default widths.
package mon_pkg;

    localparam int PULSE_W = 4;
    localparam int RST_W   = 50;
    localparam int TMO_W   = 12;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        OP_RUN     = 2'd0,
        OP_HALT    = 2'd1,
        OP_STEP    = 2'd2,
        OP_RESTART = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        RUN_IDLE,
        HALT_WAIT,
        HALT_IDLE,
        STEP_PULSE,
        STEP_RUN,
        RST_PULSE,
        RST_WAIT
    } state_e;

endpackage

// File: rtl/mon_sync_edge.sv
// Two-flop synchroniser with a rising-edge strobe.
// One extra history flop compares the synchronised level with its last sample.
module mon_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [2:0] sh_q;

    // shift the asynchronous input through the synchroniser and history flop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[1:0], d_i};
        end
    end

    assign q_o    = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/mon_step_ctrl.sv
// Monitor controller driving the timer MSTP/MSTRTP/STRT2 inputs.
// Runs, halts, single-steps or restarts the timer for a host.
module mon_step_ctrl #(
    parameter int PULSE_W = mon_pkg::PULSE_W,
    parameter int RST_W   = mon_pkg::RST_W,
    parameter int TMO_W   = mon_pkg::TMO_W,
    parameter int CNT_W   = mon_pkg::CNT_W
) (
    input  logic             SIM_CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [7:0]       CMD_N,
    input  logic             T12,
    input  logic             STOP,
    input  logic             GOJAM,
    output logic             MSTP,
    output logic             MSTRTP,
    output logic             STRT2,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic             HALTED,
    output logic [CNT_W-1:0] MCT_COUNT
);

    import mon_pkg::*;

    localparam int LEN_W = $clog2(RST_W > PULSE_W ? RST_W : PULSE_W) + 1;

    logic t12_s, t12_rise, stop_s, stop_rise, gj_s, gj_rise;
    logic unused_sync;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             hold_q, hold_d;
    logic             pstep_q, pstep_d;
    logic [7:0]       step_q, step_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             t12_seen_q, t12_seen_d;
    logic             gj_seen_q, gj_seen_d;
    logic [CNT_W-1:0] mct_q;

    logic   accept, tmo_full, counting, mstp_raw;
    logic [7:0] n_eff;
    op_e    op;

    mon_sync_edge u_sync_t12 (
        .clk_i (SIM_CLK), .rst_i (RESET), .d_i (T12),
        .q_o (t12_s), .rise_o (t12_rise)
    );

    mon_sync_edge u_sync_stop (
        .clk_i (SIM_CLK), .rst_i (RESET), .d_i (STOP),
        .q_o (stop_s), .rise_o (stop_rise)
    );

    mon_sync_edge u_sync_gj (
        .clk_i (SIM_CLK), .rst_i (RESET), .d_i (GOJAM),
        .q_o (gj_s), .rise_o (gj_rise)
    );

    assign unused_sync = t12_s ^ stop_rise;

    assign op        = op_e'(CMD_OP);
    assign n_eff     = (CMD_N == 8'd0) ? 8'd1 : CMD_N;
    assign CMD_READY = ((state_q == RUN_IDLE) | (state_q == HALT_IDLE)) & ~busy_q;
    assign accept    = CMD_VALID & CMD_READY;
    assign tmo_full  = &tmo_q;
    assign counting  = (state_q == HALT_WAIT) | (state_q == STEP_RUN)
                     | (state_q == RST_WAIT);

    // next-state, command sequencing and completion bookkeeping
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        hold_d     = hold_q;
        pstep_d    = pstep_q;
        step_d     = step_q;
        len_d      = len_q + LEN_W'(1);
        t12_seen_d = t12_seen_q | t12_rise;
        gj_seen_d  = gj_seen_q | gj_s;
        tmo_d      = (counting & ~tmo_full) ? tmo_q + TMO_W'(1) : tmo_q;
        unique case (state_q)
            RUN_IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    unique case (op)
                        OP_RUN: ;
                        OP_HALT: begin
                            state_d = HALT_WAIT;
                            pstep_d = 1'b0;
                        end
                        OP_STEP: begin
                            state_d = HALT_WAIT;
                            pstep_d = 1'b1;
                            step_d  = n_eff;
                        end
                        OP_RESTART: begin
                            state_d = RST_PULSE;
                            hold_d  = 1'b0;
                        end
                    endcase
                end else if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            HALT_WAIT: begin
                if (stop_s) begin
                    state_d = pstep_q ? STEP_PULSE : HALT_IDLE;
                end else if (tmo_full) begin
                    err_d   = 1'b1;
                    state_d = RUN_IDLE;
                end
            end
            HALT_IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    unique case (op)
                        OP_RUN:  state_d = RUN_IDLE;
                        OP_HALT: ;
                        OP_STEP: begin
                            state_d = STEP_PULSE;
                            step_d  = n_eff;
                        end
                        OP_RESTART: begin
                            state_d = RST_PULSE;
                            hold_d  = 1'b1;
                        end
                    endcase
                end else if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            STEP_PULSE: begin
                if (len_q == LEN_W'(PULSE_W - 1)) state_d = STEP_RUN;
            end
            STEP_RUN: begin
                if (gj_rise) begin
                    step_d  = 8'd0;
                    state_d = HALT_IDLE;
                end else if (t12_seen_q && stop_s) begin
                    step_d  = step_q - 8'd1;
                    state_d = (step_q == 8'd1) ? HALT_IDLE : STEP_PULSE;
                end else if (tmo_full) begin
                    err_d   = 1'b1;
                    state_d = HALT_IDLE;
                end
            end
            RST_PULSE: begin
                if (len_q == LEN_W'(RST_W - 1)) state_d = RST_WAIT;
            end
            RST_WAIT: begin
                if (gj_seen_q && !gj_s) begin
                    state_d = hold_q ? HALT_IDLE : RUN_IDLE;
                end else if (tmo_full) begin
                    err_d   = 1'b1;
                    state_d = hold_q ? HALT_IDLE : RUN_IDLE;
                end
            end
            default: state_d = RUN_IDLE;
        endcase
        if (state_d != state_q) begin
            tmo_d      = '0;
            len_d      = '0;
            t12_seen_d = 1'b0;
            gj_seen_d  = 1'b0;
        end
    end

    // controller state registers
    always_ff @(posedge SIM_CLK) begin
        if (RESET) begin
            state_q    <= RUN_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
            pstep_q    <= 1'b0;
            step_q     <= '0;
            tmo_q      <= '0;
            len_q      <= '0;
            t12_seen_q <= 1'b0;
            gj_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            pstep_q    <= pstep_d;
            step_q     <= step_d;
            tmo_q      <= tmo_d;
            len_q      <= len_d;
            t12_seen_q <= t12_seen_d;
            gj_seen_q  <= gj_seen_d;
        end
    end

    // free-running MCT profile counter, one count per T12 rise
    always_ff @(posedge SIM_CLK) begin
        if (RESET) begin
            mct_q <= '0;
        end else if (t12_rise) begin
            mct_q <= mct_q + CNT_W'(1);
        end
    end

    assign mstp_raw = (state_q == HALT_WAIT) | (state_q == HALT_IDLE)
                    | (state_q == STEP_PULSE) | (state_q == STEP_RUN)
                    | (((state_q == RST_PULSE) | (state_q == RST_WAIT)) & hold_q);

    assign MSTP      = mstp_raw & ~RESET;
    assign MSTRTP    = (state_q == STEP_PULSE);
    assign STRT2     = (state_q == RST_PULSE);
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign HALTED    = (state_q == HALT_IDLE) & stop_s;
    assign MCT_COUNT = mct_q;

endmodule

// File: tb/tb_mon_step_ctrl.sv
// Scoreboard bench for mon_step_ctrl with a behavioural timer model.
// Expected command outcomes are queued at issue and checked on DONE.
module tb_mon_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_n = 8'd0;
    logic        t12 = 1'b0;
    logic        stop = 1'b0;
    logic        gojam = 1'b0;
    logic        cmd_ready, mstp, mstrtp, strt2, busy, done, err, halted;
    logic [15:0] mct;

    mon_step_ctrl dut (
        .SIM_CLK   (clk),
        .RESET     (rst),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_OP    (cmd_op),
        .CMD_N     (cmd_n),
        .T12       (t12),
        .STOP      (stop),
        .GOJAM     (gojam),
        .MSTP      (mstp),
        .MSTRTP    (mstrtp),
        .STRT2     (strt2),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
        .HALTED    (halted),
        .MCT_COUNT (mct)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    typedef struct {
        int op;
        int err;
        int pulses;
        int mstp;
        int mct;
    } exp_t;

    exp_t sbq[$];

    // timer model: 12-cycle MCTs, T12 on the last two cycles
    bit tie_stop0 = 1'b0;
    int phase = 0;
    bit running = 1'b1;
    bit stepping = 1'b0;
    int ends = 0;
    bit s2_prev = 1'b0;
    int gj_cnt = -1;

    initial forever begin
        @(negedge clk);
        if (running) begin
            phase = (phase + 1) % 12;
            t12 = (phase >= 10);
            if (phase == 0) begin
                if (mstp && !tie_stop0) begin
                    ends++;
                    if (stepping || ends >= 3) begin
                        running = 1'b0;
                        stop = 1'b1;
                        stepping = 1'b0;
                        ends = 0;
                    end
                end else begin
                    ends = 0;
                    stepping = 1'b0;
                end
            end
        end else begin
            t12 = 1'b0;
            if (!mstp) begin
                running = 1'b1;
                stop = 1'b0;
                phase = 0;
            end else if (mstrtp) begin
                running = 1'b1;
                stepping = 1'b1;
                stop = 1'b0;
                phase = 0;
            end
        end
        if (s2_prev && !strt2) gj_cnt = 0;
        s2_prev = strt2;
        if (gj_cnt >= 0) begin
            gj_cnt++;
            gojam = (gj_cnt > 3 && gj_cnt <= 9);
            if (gj_cnt > 12) gj_cnt = -1;
        end
    end

    // monitor: tracks pulses during a command, scores on DONE
    bit          active = 1'b0;
    int          pulses = 0;
    int          prun = 0;
    int          s2len = 0;
    int          cyc = 0;
    logic [15:0] mct0 = '0;
    bit          prev_p = 1'b0;
    bit          gj_hi = 1'b0;
    bit          gj_fell = 1'b0;
    bit          mstp0 = 1'b0;
    bit          mstp_chg = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
            prun = 0;
            prev_p = 1'b0;
        end else begin
            if (mstrtp) begin
                prun++;
            end else if (prev_p) begin
                check("mstrtp_width", prun, 4);
                prun = 0;
            end
            if (active) begin
                cyc++;
                if (mstrtp && !prev_p) pulses++;
                if (strt2) s2len++;
                if (gojam) gj_hi = 1'b1;
                else if (gj_hi) gj_fell = 1'b1;
                if (mstp !== mstp0) mstp_chg = 1'b1;
            end
            prev_p = mstrtp;
            if (done) begin
                if (sbq.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("done_err", int'(err), e.err);
                    check("done_mstp", int'(mstp), e.mstp);
                    check("done_halted", int'(halted), e.mstp);
                    check("done_busy", int'(busy), 0);
                    check("done_ready", int'(cmd_ready), 1);
                    check("step_pulses", pulses, e.pulses);
                    if (e.mct >= 0)
                        check("mct_delta", int'(16'(mct - mct0)), e.mct);
                    if (e.op == 3) begin
                        check("strt2_width", s2len, 50);
                        check("gojam_hi_lo", int'(gj_fell), 1);
                        check("restart_mstp_const", int'(mstp_chg), 0);
                    end
                    if (e.err != 0)
                        check("tmo_cycles", int'(cyc >= 4095 && cyc <= 4100), 1);
                end
                active = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                active = 1'b1;
                pulses = 0;
                s2len = 0;
                cyc = 0;
                mct0 = mct;
                gj_hi = 1'b0;
                gj_fell = 1'b0;
                mstp0 = mstp;
                mstp_chg = 1'b0;
            end
        end
    end

    // reference model state: is the timer held by the monitor
    bit m_halted = 1'b0;

    task automatic wait_ready();
        int g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while (!cmd_ready && g < 2000);
        check("ready_before_cmd", int'(cmd_ready), 1);
    endtask

    task automatic issue(input int op, input int n, input bit tmo);
        exp_t x;
        int   g;
        wait_ready();
        x.op     = op;
        x.err    = tmo ? 1 : 0;
        x.pulses = (op == 2) ? ((n == 0) ? 1 : n) : 0;
        case (op)
            0:       x.mstp = 0;
            1, 2:    x.mstp = tmo ? 0 : 1;
            default: x.mstp = m_halted ? 1 : 0;
        endcase
        x.mct = (m_halted && op != 0) ? x.pulses : -1;
        sbq.push_back(x);
        cmd_valid = 1'b1;
        cmd_op = 2'(op);
        cmd_n = 8'(n);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("busy_on_accept", int'(busy), 1);
        check("ready_on_accept", int'(cmd_ready), 0);
        check("err_clr_on_accept", int'(err), 0);
        if ((op == 1 || op == 2) && !m_halted)
            check("mstp_after_accept", int'(mstp), 1);
        m_halted = (x.mstp != 0);
        g = 0;
        while (sbq.size() != 0 && g < 6000) begin
            @(posedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            check("done_timeout", 0, 1);
            sbq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_mstp", int'(mstp), 0);
        check("rst_mstrtp", int'(mstrtp), 0);
        check("rst_strt2", int'(strt2), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_mct", int'(mct), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        issue(1, 0, 1'b0);
        issue(2, 3, 1'b0);
        issue(0, 0, 1'b0);
        issue(2, 0, 1'b0);
        issue(0, 0, 1'b0);

        tie_stop0 = 1'b1;
        issue(1, 0, 1'b1);
        tie_stop0 = 1'b0;
        issue(0, 0, 1'b0);

        issue(3, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0);
        end

        issue(1, 0, 1'b0);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        cmd_n = 8'd5;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        g = 0;
        while (!mstrtp && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("reach_step_pulse", int'(mstrtp), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mstrtp", int'(mstrtp), 0);
        check("abort_mstp", int'(mstp), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_mct", int'(mct), 0);
        check("abort_done", int'(done), 0);
        check("abort_ready", int'(cmd_ready), 1);
        sbq.delete();
        m_halted = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        issue(0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
